bus_deserializer: RTL and testbench

Collects a one-bit serial stream into a WIDTH-bit parallel bus word, the inverse of our bus-reduction netlists, so a single net can be fanned back out into a bus such as a 4-bit input vector. The block sits between a serial producer and a bus consumer. Both sides use valid/ready handshakes. Short frames are flushed as zero-padded partial words.

---
 rtl/bus_deserializer_pkg.sv | 23 ++
 rtl/bus_deserializer.sv | 107 ++++++++++
 tb/tb_bus_deserializer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel bus deserializer.
package bus_deserializer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned MAX_WIDTH     = 64;

   typedef enum logic {
      COLLECT = 1'b0,
      PEND    = 1'b1
   } state_t;

   // Keep only the lowest 'count' bits of a word; upper bits forced to zero.
   function automatic logic [MAX_WIDTH-1:0] mask_word(input logic [MAX_WIDTH-1:0] word,
                                                     input int unsigned          count);
      logic [MAX_WIDTH-1:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i < count) mask[i] = 1'b1;
      end
      return word & mask;
   endfunction

endpackage

// File: rtl/bus_deserializer.sv
// Collects a serial bit stream into WIDTH-bit words with valid/ready on both sides;
// frames closed early by SerLast are emitted as zero-padded partial words.
module bus_deserializer
   import bus_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             SerIn,
   input  logic             SerValid,
   input  logic             SerLast,
   output logic             SerReady,
   output logic [WIDTH-1:0] BusOut,
   output logic             BusValid,
   input  logic             BusReady,
   output logic [CNT_W-1:0] BusCount,
   output logic             BusPartial
);

   state_t           state_q;
   logic [WIDTH-1:0] asm_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ser_ready_q;
   logic [WIDTH-1:0] bus_out_q;
   logic             bus_valid_q;
   logic [CNT_W-1:0] bus_count_q;
   logic             bus_partial_q;

   logic             accept_c;
   logic             drain_c;
   logic             out_free_c;
   logic             done_c;
   logic [CNT_W-1:0] cnt_inc_c;
   logic [WIDTH-1:0] asm_nxt_c;
   logic [WIDTH-1:0] load_word_c;
   logic [WIDTH-1:0] pend_word_c;

   // Handshake decode and the word as it would look with the current bit merged in.
   always_comb begin
      accept_c    = SerValid && (state_q == COLLECT);
      drain_c     = bus_valid_q && BusReady;
      out_free_c  = !bus_valid_q || BusReady;
      cnt_inc_c   = cnt_q + CNT_W'(1);
      asm_nxt_c   = asm_q | (WIDTH'(SerIn) << cnt_q);
      done_c      = accept_c && ((cnt_inc_c == CNT_W'(WIDTH)) || SerLast);
      load_word_c = WIDTH'(mask_word(MAX_WIDTH'(asm_nxt_c), 32'(cnt_inc_c)));
      pend_word_c = WIDTH'(mask_word(MAX_WIDTH'(asm_q), 32'(cnt_q)));
   end

   // In PEND the counter keeps the finished word's length until it can be loaded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= COLLECT;
         asm_q         <= '0;
         cnt_q         <= '0;
         ser_ready_q   <= 1'b1;
         bus_out_q     <= '0;
         bus_valid_q   <= 1'b0;
         bus_count_q   <= '0;
         bus_partial_q <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (done_c && out_free_c) begin
                  bus_out_q     <= load_word_c;
                  bus_valid_q   <= 1'b1;
                  bus_count_q   <= cnt_inc_c;
                  bus_partial_q <= (cnt_inc_c < CNT_W'(WIDTH));
                  asm_q         <= '0;
                  cnt_q         <= '0;
               end else begin
                  if (accept_c) begin
                     asm_q <= asm_nxt_c;
                     cnt_q <= cnt_inc_c;
                  end
                  if (done_c) begin
                     state_q     <= PEND;
                     ser_ready_q <= 1'b0;
                  end
                  if (drain_c) bus_valid_q <= 1'b0;
               end
            end
            PEND: begin
               if (drain_c) begin
                  bus_out_q     <= pend_word_c;
                  bus_valid_q   <= 1'b1;
                  bus_count_q   <= cnt_q;
                  bus_partial_q <= (cnt_q < CNT_W'(WIDTH));
                  asm_q         <= '0;
                  cnt_q         <= '0;
                  state_q       <= COLLECT;
                  ser_ready_q   <= 1'b1;
               end
            end
         endcase
      end
   end

   assign SerReady   = ser_ready_q;
   assign BusOut     = bus_out_q;
   assign BusValid   = bus_valid_q;
   assign BusCount   = bus_count_q;
   assign BusPartial = bus_partial_q;

endmodule

// File: tb/tb_bus_deserializer.sv
// Self-checking bench for bus_deserializer: directed scenarios plus randomized
// traffic against a frame-level reference model (bit queue + expected-word queue).
module tb_bus_deserializer;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          SerIn = 1'b0;
   logic          SerValid = 1'b0;
   logic          SerLast = 1'b0;
   logic          BusReady = 1'b0;
   logic          SerReady;
   logic [W-1:0]  BusOut;
   logic          BusValid;
   logic [CW-1:0] BusCount;
   logic          BusPartial;

   typedef struct {
      logic [W-1:0] word;
      int           count;
      logic         partial;
      bit           ok;
   } exp_t;

   bit   frame[$];
   exp_t expq[$];

   int tests = 0;
   int fails = 0;

   bit            m_drained;
   exp_t          m_ex;
   logic [W-1:0]  o_word;
   logic [CW-1:0] o_count;
   logic          o_partial;

   always #5 clk = ~clk;

   bus_deserializer #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SerIn     (SerIn),
      .SerValid  (SerValid),
      .SerLast   (SerLast),
      .SerReady  (SerReady),
      .BusOut    (BusOut),
      .BusValid  (BusValid),
      .BusReady  (BusReady),
      .BusCount  (BusCount),
      .BusPartial(BusPartial)
   );

   // Drive one cycle, advance the model by its own handshake rules, sample #1 after the edge.
   task automatic step(input logic sin, input logic sv, input logic sl, input logic br);
      bit mready;
      bit mvalid;
      SerIn = sin; SerValid = sv; SerLast = sl; BusReady = br;
      mready    = (expq.size() < 2);
      mvalid    = (expq.size() > 0);
      m_drained = mvalid && br;
      o_word    = BusOut;
      o_count   = BusCount;
      o_partial = BusPartial;
      m_ex      = '{word: '0, count: 0, partial: 1'b0, ok: 1'b0};
      if (m_drained) m_ex = expq.pop_front();
      if (sv && mready) begin
         frame.push_back(sin);
         if (frame.size() == W || sl) begin
            exp_t e;
            e.word = '0;
            foreach (frame[k]) e.word[k] = frame[k];
            e.count   = frame.size();
            e.partial = (frame.size() < W);
            e.ok      = 1'b1;
            expq.push_back(e);
            frame.delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; SerValid = 1'b0; SerLast = 1'b0; SerIn = 1'b0; BusReady = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      frame.delete();
      expq.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tests++; if (SerReady !== 1'b1) begin fails++; $display("FAIL reset_serready got %b want 1", SerReady); end
      tests++; if (BusValid !== 1'b0) begin fails++; $display("FAIL reset_busvalid got %b want 0", BusValid); end
      tests++; if (BusOut !== '0) begin fails++; $display("FAIL reset_busout got %b want 0000", BusOut); end
      tests++; if (BusCount !== '0) begin fails++; $display("FAIL reset_buscount got %0d want 0", BusCount); end
      tests++; if (BusPartial !== 1'b0) begin fails++; $display("FAIL reset_buspartial got %b want 0", BusPartial); end
   endtask

   task automatic test_full_word();
      logic [3:0] pat;
      int vcnt;
      pat = 4'b1101;
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(pat[i], 1'b1, 1'b0, 1'b1);
         if (BusValid === 1'b1) vcnt++;
      end
      tests++; if (BusValid !== 1'b1) begin fails++; $display("FAIL full_valid_latency got %b want 1", BusValid); end
      tests++; if (BusOut !== 4'b1101) begin fails++; $display("FAIL full_word got %b want 1101", BusOut); end
      tests++; if (BusCount !== CW'(4)) begin fails++; $display("FAIL full_count got %0d want 4", BusCount); end
      tests++; if (BusPartial !== 1'b0) begin fails++; $display("FAIL full_partial got %b want 0", BusPartial); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (BusValid === 1'b1) vcnt++;
      tests++;
      if (!m_drained || !m_ex.ok || o_word !== m_ex.word || o_count !== CW'(m_ex.count)) begin
         fails++; $display("FAIL full_drain got %b/%0d want %b/%0d", o_word, o_count, m_ex.word, m_ex.count);
      end
      tests++; if (vcnt != 1) begin fails++; $display("FAIL full_valid_width got %0d cycles want 1", vcnt); end
   endtask

   task automatic test_partial();
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      tests++; if (BusValid !== 1'b1) begin fails++; $display("FAIL partial_valid got %b want 1", BusValid); end
      tests++; if (BusOut !== 4'b0011) begin fails++; $display("FAIL partial_word got %b want 0011", BusOut); end
      tests++; if (BusCount !== CW'(2)) begin fails++; $display("FAIL partial_count got %0d want 2", BusCount); end
      tests++; if (BusPartial !== 1'b1) begin fails++; $display("FAIL partial_flag got %b want 1", BusPartial); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [7:0] data;
      data = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         step(data[i], 1'b1, 1'b0, 1'b0);
         if (i >= 3) begin
            tests++;
            if (BusValid !== 1'b1 || BusOut !== 4'b1010) begin
               fails++; $display("FAIL bp_hold cycle %0d got %b/%b want 1/1010", i, BusValid, BusOut);
            end
         end
         tests++;
         if (SerReady !== (i < 7 ? 1'b1 : 1'b0)) begin
            fails++; $display("FAIL bp_serready cycle %0d got %b want %b", i, SerReady, (i < 7));
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tests++; if (SerReady !== 1'b0 || BusOut !== 4'b1010) begin
         fails++; $display("FAIL bp_stall got %b/%b want 0/1010", SerReady, BusOut);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      tests++; if (!m_drained || !m_ex.ok || o_word !== 4'b1010 || m_ex.word !== 4'b1010) begin
         fails++; $display("FAIL bp_first_drain got %b want 1010", o_word);
      end
      tests++; if (BusValid !== 1'b1 || BusOut !== 4'b0101) begin
         fails++; $display("FAIL bp_second_word got %b/%b want 1/0101", BusValid, BusOut);
      end
      tests++; if (SerReady !== 1'b1) begin fails++; $display("FAIL bp_ready_return got %b want 1", SerReady); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      tests++; if (BusValid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", BusValid); end
   endtask

   task automatic test_back_to_back();
      int hi, rises, srlow, drains;
      logic prev;
      hi = 0; rises = 0; srlow = 0; drains = 0; prev = 1'b0;
      for (int i = 0; i < 13; i++) begin
         if (i < 12) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
         else        step(1'b0, 1'b0, 1'b0, 1'b1);
         if (BusValid === 1'b1) hi++;
         if (BusValid === 1'b1 && prev !== 1'b1) rises++;
         prev = BusValid;
         if (i < 12 && SerReady !== 1'b1) srlow++;
         if (m_drained) begin
            drains++;
            tests++;
            if (!m_ex.ok || o_word !== m_ex.word || o_count !== CW'(m_ex.count) || o_partial !== m_ex.partial) begin
               fails++; $display("FAIL b2b_word got %b/%0d want %b/%0d", o_word, o_count, m_ex.word, m_ex.count);
            end
         end
      end
      tests++; if (hi != 3 || rises != 3) begin fails++; $display("FAIL b2b_pulses got %0d high %0d rises want 3 3", hi, rises); end
      tests++; if (srlow != 0) begin fails++; $display("FAIL b2b_serready got %0d low cycles want 0", srlow); end
      tests++; if (drains != 3) begin fails++; $display("FAIL b2b_drains got %0d want 3", drains); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      tests++; if (BusValid !== 1'b1 || BusOut !== 4'b1000 || BusCount !== CW'(4) || BusPartial !== 1'b0) begin
         fails++; $display("FAIL rst_mid_word got %b/%b/%0d/%b want 1/1000/4/0", BusValid, BusOut, BusCount, BusPartial);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_pend();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      tests++; if (SerReady !== 1'b0) begin fails++; $display("FAIL rst_pend_entry got %b want 0", SerReady); end
      do_reset();
      tests++; if (BusValid !== 1'b0 || SerReady !== 1'b1) begin
         fails++; $display("FAIL rst_pend_clear got %b/%b want 0/1", BusValid, SerReady);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      tests++; if (BusOut !== 4'b0001 || BusCount !== CW'(4)) begin
         fails++; $display("FAIL rst_pend_word got %b/%0d want 0001/4", BusOut, BusCount);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      tests++; if (BusValid !== 1'b0) begin fails++; $display("FAIL rst_pend_leftover got %b want 0", BusValid); end
   endtask

   task automatic test_first_last();
      step(1'b1, 1'b1, 1'b1, 1'b1);
      tests++; if (BusOut !== 4'b0001 || BusCount !== CW'(1) || BusPartial !== 1'b1) begin
         fails++; $display("FAIL first_last got %b/%0d/%b want 0001/1/1", BusOut, BusCount, BusPartial);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [W-1:0]  hold_word;
      logic [CW-1:0] hold_count;
      bit            holding;
      do_reset();
      holding = 1'b0;
      for (int i = 0; i < 600; i++) begin
         logic sv, sl, br;
         sv = ($urandom_range(0, 3) != 0);
         sl = ($urandom_range(0, 4) == 0);
         br = ($urandom_range(0, 2) != 0);
         tests++;
         if (SerReady !== (expq.size() < 2) || BusValid !== (expq.size() > 0)) begin
            fails++; $display("FAIL rand_flags cycle %0d got rdy %b vld %b want %b %b",
                              i, SerReady, BusValid, (expq.size() < 2), (expq.size() > 0));
         end
         if (holding) begin
            tests++;
            if (BusOut !== hold_word || BusCount !== hold_count) begin
               fails++; $display("FAIL rand_stable cycle %0d got %b/%0d want %b/%0d", i, BusOut, BusCount, hold_word, hold_count);
            end
         end
         holding    = (BusValid === 1'b1) && !br;
         hold_word  = BusOut;
         hold_count = BusCount;
         step(1'($urandom_range(0, 1)), sv, sl, br);
         if (m_drained) begin
            tests++;
            if (!m_ex.ok || o_word !== m_ex.word || o_count !== CW'(m_ex.count) || o_partial !== m_ex.partial) begin
               fails++; $display("FAIL rand_word cycle %0d got %b/%0d/%b want %b/%0d/%b",
                                 i, o_word, o_count, o_partial, m_ex.word, m_ex.count, m_ex.partial);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         if (m_drained) begin
            tests++;
            if (!m_ex.ok || o_word !== m_ex.word || o_count !== CW'(m_ex.count)) begin
               fails++; $display("FAIL rand_tail got %b/%0d want %b/%0d", o_word, o_count, m_ex.word, m_ex.count);
            end
         end
      end
      tests++; if (BusValid !== 1'b0 || expq.size() != 0) begin
         fails++; $display("FAIL rand_drained got vld %b queue %0d want 0 0", BusValid, expq.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout tests %0d failed %0d", tests, fails);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_reset_pend();
      test_first_last();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
